pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64, giving the maximum cycles spent waiting for mdu_done before abort.
REQ-002 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rs1_ID, rs2_ID, input, 5 each, the ID-stage source registers.
REQ-005 SHALL have ports uses_rs1_ID, uses_rs2_ID, is_branch_ID, branch_taken_ID, input, 1 each: the ID source registers are read, the ID instruction is a branch or JALR, and the ID branch resolved taken.
REQ-006 SHALL have ports rd_EX, rd_MEM, input, 5 each, and MemRead_EX, MemRead_MEM, input, 1 each, giving the load destinations in EX and MEM.
REQ-007 SHALL have ports mdu_req_EX, input, 1 (EX holds a multi-cycle mul/div op), and mdu_done, input, 1 (MDU result valid this cycle).
REQ-008 SHALL have outputs stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX, bubble_MEM, mdu_start, mdu_timeout_err, each 1 bit.
REQ-009 SHALL have output stall_count, 16 bits, a saturating count of cycles with stall_IF=1.

Function
REQ-010 SHALL implement states RUN and MDU_BUSY, plus a 7-bit wait counter and the stall_count register.
REQ-011 SHALL define match(r) as r!=0 and ((uses_rs1_ID and r==rs1_ID) or (uses_rs2_ID and r==rs2_ID)).
REQ-012 SHALL raise load_use when MemRead_EX and match(rd_EX).
REQ-013 SHALL raise br_hazard when is_branch_ID and MemRead_MEM and match(rd_MEM), since ALU results forward to ID and loads in MEM do not.
REQ-014 SHALL, in RUN with mdu_req_EX=0, drive stall_IF=stall_ID=bubble_EX=(load_use or br_hazard), with hold_EX=bubble_MEM=0, all combinationally in the same cycle.
REQ-015 SHALL give a load-use before a branch two stall cycles: load_use with rd_EX first, then br_hazard with rd_MEM.
REQ-016 SHALL drive flush_ID=branch_taken_ID only when stall_ID=0; a taken indication during a stall is ignored.
REQ-017 SHALL, in RUN with mdu_req_EX=1, assert mdu_start for exactly that cycle plus stall_IF, stall_ID, hold_EX and bubble_MEM, set bubble_EX=0, clear the wait counter, and go to MDU_BUSY.
REQ-018 SHALL, in MDU_BUSY with mdu_done=0, assert stall_IF, stall_ID, hold_EX and bubble_MEM, with bubble_EX=flush_ID=mdu_start=0, and increment the wait counter.
REQ-019 SHALL, in MDU_BUSY with mdu_done=1, deassert all stall, hold and bubble outputs in that same cycle so the result advances, and return to RUN.
REQ-020 SHALL give mdu_done priority over timeout when both occur in the same cycle.
REQ-021 SHALL, in MDU_BUSY when the wait counter reaches MDU_TIMEOUT-1 without mdu_done, set sticky mdu_timeout_err, release hold as in REQ-019, and return to RUN.
REQ-022 SHALL let MDU hold override load_use and br_hazard, which are not acted on while hold_EX=1.
REQ-023 SHALL increment stall_count on every clock edge where stall_IF=1, saturating at 16'hFFFF with no wrap.
REQ-024 SHALL have no mdu_start retrigger for the completed op, because EX receives a new instruction on the mdu_done edge.

Reset
REQ-025 SHALL, while rst=1, force state RUN, wait counter 0, stall_count 0 and mdu_timeout_err 0 asynchronously.
REQ-026 SHALL abort MDU_BUSY immediately on rst, dropping hold_EX, without waiting for mdu_done.
REQ-027 SHALL, with rst=1, force all combinational outputs to 0 regardless of inputs.

Verification
REQ-028 SHALL cover: MemRead_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 -> stall_IF=stall_ID=bubble_EX=1 for one cycle, stall_count=1.
REQ-029 SHALL cover: a load to x7 followed by a branch reading x7 -> two consecutive stall cycles (load_use, then br_hazard), then flush_ID=1 if taken.
REQ-030 SHALL cover: a load to x0 used by ID -> no stall.
REQ-031 SHALL cover: mdu_req_EX=1 with mdu_done after 5 cycles -> mdu_start pulse of 1 cycle, hold_EX=1 for 5 cycles, 0 on the done cycle, state RUN.
REQ-032 SHALL cover: MDU with no done and MDU_TIMEOUT=8 -> hold for 8 cycles, then mdu_timeout_err=1 sticky until rst.
REQ-033 SHALL cover: rst asserted mid-MDU_BUSY, and stall_count preloaded near 16'hFFFF with further stalls -> outputs 0 immediately on reset; the count holds at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use and branch-operand stalls, branch flush,
// and EX hold while a multi-cycle mul/div unit is busy, with a bounded wait.
module pipeline_hazard_controller #(
   parameter int MDU_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic        uses_rs1_ID,
   input  logic        uses_rs2_ID,
   input  logic        is_branch_ID,
   input  logic        branch_taken_ID,
   input  logic [4:0]  rd_EX,
   input  logic [4:0]  rd_MEM,
   input  logic        MemRead_EX,
   input  logic        MemRead_MEM,
   input  logic        mdu_req_EX,
   input  logic        mdu_done,
   output logic        stall_IF,
   output logic        stall_ID,
   output logic        bubble_EX,
   output logic        flush_ID,
   output logic        hold_EX,
   output logic        bubble_MEM,
   output logic        mdu_start,
   output logic        mdu_timeout_err,
   output logic [15:0] stall_count
);

   typedef enum logic {RUN, MDU_BUSY} state_t;

   localparam logic [6:0] WAIT_LAST = 7'(MDU_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [6:0]  wait_q, wait_d;
   logic        err_d;
   logic        match_ex, match_mem, load_use, br_hazard;

   assign match_ex  = (rd_EX != 5'd0) &&
                      ((uses_rs1_ID && rd_EX == rs1_ID) || (uses_rs2_ID && rd_EX == rs2_ID));
   assign match_mem = (rd_MEM != 5'd0) &&
                      ((uses_rs1_ID && rd_MEM == rs1_ID) || (uses_rs2_ID && rd_MEM == rs2_ID));
   assign load_use  = MemRead_EX && match_ex;
   // ALU results forward into ID for branch compare; a load still in MEM does not.
   assign br_hazard = is_branch_ID && MemRead_MEM && match_mem;

   // NOTE: every output and next-state variable gets a default before the case,
   // so no path through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      err_d      = mdu_timeout_err;
      stall_IF   = 1'b0;
      stall_ID   = 1'b0;
      bubble_EX  = 1'b0;
      hold_EX    = 1'b0;
      bubble_MEM = 1'b0;
      mdu_start  = 1'b0;
      flush_ID   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (mdu_req_EX) begin
                  mdu_start  = 1'b1;
                  stall_IF   = 1'b1;
                  stall_ID   = 1'b1;
                  hold_EX    = 1'b1;
                  bubble_MEM = 1'b1;
                  wait_d     = 7'd0;
                  state_d    = MDU_BUSY;
               end else begin
                  stall_IF  = load_use || br_hazard;
                  stall_ID  = load_use || br_hazard;
                  bubble_EX = load_use || br_hazard;
               end
            end
            MDU_BUSY: begin
               // Done wins over timeout; both release the hold in this same cycle.
               if (mdu_done) begin
                  state_d = RUN;
               end else if (wait_q == WAIT_LAST) begin
                  err_d   = 1'b1;
                  state_d = RUN;
               end else begin
                  stall_IF   = 1'b1;
                  stall_ID   = 1'b1;
                  hold_EX    = 1'b1;
                  bubble_MEM = 1'b1;
                  wait_d     = wait_q + 7'd1;
               end
            end
            default: state_d = RUN;
         endcase
         flush_ID = branch_taken_ID && !stall_ID;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= RUN;
         wait_q          <= 7'd0;
         mdu_timeout_err <= 1'b0;
         stall_count     <= 16'd0;
      end else begin
         state_q         <= state_d;
         wait_q          <= wait_d;
         mdu_timeout_err <= err_d;
         if (stall_IF && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: per-cycle expected outputs are
// queued as stimulus is applied and checked once the combinational outputs settle.
module tb_pipeline_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_ID, rs2_ID, rd_EX, rd_MEM;
   logic        uses_rs1_ID, uses_rs2_ID, is_branch_ID, branch_taken_ID;
   logic        MemRead_EX, MemRead_MEM, mdu_req_EX, mdu_done;
   logic        stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX, bubble_MEM;
   logic        mdu_start, mdu_timeout_err;
   logic [15:0] stall_count;

   typedef struct packed {
      logic [7:0]  outs;
      logic [15:0] cnt;
   } exp_t;

   // outs = {stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX, bubble_MEM, mdu_start, mdu_timeout_err}
   localparam logic [7:0] NONE = 8'b0000_0000;
   localparam logic [7:0] STL  = 8'b1110_0000;
   localparam logic [7:0] FLS  = 8'b0001_0000;
   localparam logic [7:0] MST  = 8'b1100_1110;
   localparam logic [7:0] MBZ  = 8'b1100_1100;
   localparam logic [7:0] ERR  = 8'b0000_0001;

   exp_t        sb_q[$];
   logic [15:0] exp_cnt;
   int          tests_run = 0;
   int          tests_failed = 0;

   pipeline_hazard_controller #(.MDU_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
      .is_branch_ID(is_branch_ID), .branch_taken_ID(branch_taken_ID),
      .rd_EX(rd_EX), .rd_MEM(rd_MEM),
      .MemRead_EX(MemRead_EX), .MemRead_MEM(MemRead_MEM),
      .mdu_req_EX(mdu_req_EX), .mdu_done(mdu_done),
      .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
      .flush_ID(flush_ID), .hold_EX(hold_EX), .bubble_MEM(bubble_MEM),
      .mdu_start(mdu_start), .mdu_timeout_err(mdu_timeout_err),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0; rd_MEM = 5'd0;
      uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; is_branch_ID = 1'b0; branch_taken_ID = 1'b0;
      MemRead_EX = 1'b0; MemRead_MEM = 1'b0; mdu_req_EX = 1'b0; mdu_done = 1'b0;
   endtask

   // Inputs are already applied just after a falling edge; queue the expectation,
   // let logic settle, compare, advance the count model, move to the next falling edge.
   task automatic cyc(input string tag, input logic [7:0] exp_outs);
      exp_t e;
      logic [7:0] got;
      sb_q.push_back('{outs: exp_outs, cnt: exp_cnt});
      #1;
      e   = sb_q.pop_front();
      got = {stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX, bubble_MEM, mdu_start, mdu_timeout_err};
      tests_run++;
      assert (got === e.outs) else begin
         tests_failed++;
         $error("FAIL %s outs: got %b expected %b", tag, got, e.outs);
      end
      tests_run++;
      assert (stall_count === e.cnt) else begin
         tests_failed++;
         $error("FAIL %s stall_count: got %0d expected %0d", tag, stall_count, e.cnt);
      end
      if (!rst && e.outs[7] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
   endtask

   task automatic load_use_on();
      MemRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; uses_rs1_ID = 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      exp_cnt = 16'd0;
      @(negedge clk);

      // Reset forces outputs low even with a live load-use hazard
      load_use_on();
      cyc("reset_forced", NONE);
      rst = 1'b0;
      clear_inputs();
      cyc("idle", NONE);

      // Basic load-use on rs1
      load_use_on();
      cyc("load_use_rs1", STL);
      clear_inputs();
      cyc("after_load_use", NONE);

      // rs2 match only counts when rs2 is read
      MemRead_EX = 1'b1; rd_EX = 5'd9; rs2_ID = 5'd9; uses_rs2_ID = 1'b1;
      cyc("load_use_rs2", STL);
      uses_rs2_ID = 1'b0;
      cyc("rs2_unused", NONE);
      uses_rs2_ID = 1'b1; MemRead_EX = 1'b0;
      cyc("not_a_load", NONE);

      // Load to x0 never stalls
      clear_inputs();
      MemRead_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; uses_rs1_ID = 1'b1;
      cyc("load_x0", NONE);

      // Load x7 then taken branch on x7: two stalls, flush only after
      clear_inputs();
      MemRead_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; uses_rs1_ID = 1'b1;
      is_branch_ID = 1'b1; branch_taken_ID = 1'b1;
      cyc("br_load_ex", STL);
      MemRead_EX = 1'b0; rd_EX = 5'd0; MemRead_MEM = 1'b1; rd_MEM = 5'd7;
      cyc("br_load_mem", STL);
      MemRead_MEM = 1'b0; rd_MEM = 5'd0;
      cyc("br_flush", FLS);
      // Non-branch with the load in MEM is served by the normal bypass
      is_branch_ID = 1'b0; branch_taken_ID = 1'b0; MemRead_MEM = 1'b1; rd_MEM = 5'd7;
      cyc("nonbranch_mem_load", NONE);

      // MDU op done after five held cycles; load-use ignored while held
      clear_inputs();
      mdu_req_EX = 1'b1;
      cyc("mdu_start", MST);
      load_use_on();
      for (int i = 0; i < 4; i++) cyc("mdu_busy", MBZ);
      clear_inputs();
      mdu_req_EX = 1'b1; mdu_done = 1'b1;
      cyc("mdu_done_release", NONE);
      clear_inputs();
      cyc("mdu_back_run", NONE);
      load_use_on();
      cyc("run_load_use", STL);

      // Done arriving on the timeout cycle wins: no error
      clear_inputs();
      mdu_req_EX = 1'b1;
      cyc("mdu2_start", MST);
      for (int i = 0; i < 7; i++) cyc("mdu2_busy", MBZ);
      mdu_done = 1'b1;
      cyc("mdu2_done_at_limit", NONE);
      clear_inputs();
      cyc("mdu2_no_err", NONE);

      // Timeout: eight held cycles, then sticky error
      mdu_req_EX = 1'b1;
      cyc("mdu3_start", MST);
      for (int i = 0; i < 7; i++) cyc("mdu3_busy", MBZ);
      cyc("mdu3_timeout", NONE);
      clear_inputs();
      cyc("err_sticky", ERR);
      load_use_on();
      cyc("err_sticky_stall", STL | ERR);

      // Reset in the middle of a wait aborts the hold at once
      clear_inputs();
      mdu_req_EX = 1'b1;
      cyc("mdu4_start", MST | ERR);
      cyc("mdu4_busy", MBZ | ERR);
      rst = 1'b1;
      exp_cnt = 16'd0;
      cyc("mdu4_reset", NONE);
      rst = 1'b0;
      clear_inputs();
      cyc("post_reset_run", NONE);

      // Saturation of stall_count
      load_use_on();
      repeat (65530) @(negedge clk);
      exp_cnt = 16'd65530;
      for (int i = 0; i < 8; i++) cyc("sat_stall", STL);
      clear_inputs();
      cyc("sat_hold", NONE);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
